serial_sum_decoder: RTL and testbench
=====================================

# serial_sum_decoder

Bit-serial inverse of the 4-bit ripple-carry adder datapath: given a 5-bit sum, the addend B and the carry-in, it recovers the other addend A = SUM − B − CIN. It processes one bit per clock using a full-subtractor cell and a borrow flip-flop. It flags whether the recovered A is representable in WIDTH bits, which confirms that the sum was produced by the forward adder. It sits downstream of the adder on the switch/LED lab datapath and is controlled with a start/done handshake.

## Interface

- WIDTH, 4, operand width in bits; sum is WIDTH+1 bits.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-high.
- start  input  1  request; sampled only in IDLE.
- sum  input  WIDTH+1  adder result, MSB is the carry-out.
- b  input  WIDTH  known addend.
- cin  input  1  carry-in used by the forward addition.
- busy  output  1  high in SHIFT.
- done  output  1  one-cycle pulse when the result is ready.
- a  output  WIDTH  recovered addend; held until the next accepted start.
- valid  output  1  high when SUM − B − CIN lies in [0, 2^WIDTH − 1]; held with a.

## Operation

- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - When start=1, latch sum, b and cin into internal shift registers.
  - Set borrow := cin and bit counter := 0, then go to SHIFT.
  - When start=0, stay in IDLE.
- SHIFT, one bit per cycle, LSB first, using s = sum_reg[0] and y = b_reg[0]:
  - d = s ^ y ^ borrow.
  - borrow_next = (~s & y) | (~s & borrow) | (y & borrow).
  - a_reg shifts right with d inserted at the MSB.
  - sum_reg and b_reg shift right.
  - The counter increments; after the WIDTH-th bit, go to DONE.
- DONE:
  - valid := ~(sum[WIDTH] ^ borrow), using the latched carry-out bit.
  - Result is invalid if borrow=1 with sum MSB=0 (negative) or borrow=0 with sum MSB=1 (≥ 2^WIDTH).
  - Pulse done, drive a from a_reg, return to IDLE.
- start while busy or in DONE is ignored and not queued.
- Inputs may change freely after the start cycle; only the latched copies are used.
- When valid=0, a holds the low WIDTH bits of the two's-complement difference.

## Timing

- Reset (asynchronous, any state, including mid-SHIFT): state=IDLE; busy=0, done=0, valid=0, a=0; borrow, counter and shift registers cleared.
- Any in-flight operation is discarded on reset. The first start accepted after rst deasserts behaves normally.
- Start is sampled at edge T0.
- busy=1 for the cycles following edges T0 through T0+WIDTH−1.
- done=1 for exactly one cycle after edge T0+WIDTH; a and valid update at that same edge.
- Latency from start to done is WIDTH+1 edges; throughput is one operation per WIDTH+2 cycles.
- If start is held high continuously, a new operation is accepted at the first IDLE cycle after DONE.
- a and valid change only at the DONE edge or on reset.

## Test plan

- sum=9, b=5, cin=1, start pulse:
  - done exactly 5 cycles after start.
  - a=3, valid=1.
  - busy high for 4 cycles.
- sum=31, b=15, cin=1 -> a=15, valid=1.
- sum=0, b=0, cin=1 -> a=15, valid=0 (negative result).
- sum=20, b=0, cin=0 -> a=4, valid=0 (overflow).
- Start with sum=9, b=5, cin=1; pulse start again 2 cycles later with different operands:
  - The second start is ignored.
  - Result is a=3 with a single done pulse.
- Assert rst 2 cycles into SHIFT:
  - All outputs are 0 immediately, without waiting for a clock edge.
  - No done pulse follows.
  - The next operation (sum=6, b=2, cin=0) yields a=4, valid=1.
- Exhaustive round trip over all A, B in 0..15 and cin in {0,1}: feed the reference adder sum -> a=A and valid=1 for every case.

Source files
------------

// File: rtl/serial_sum_decoder.sv
// Bit-serial recovery of addend A = SUM - B - CIN using a full-subtractor cell
// and a borrow flip-flop, with a start/busy/done handshake.
module serial_sum_decoder #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH:0]   sum,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] a,
  output logic             valid
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] sum_reg;
  logic             cout_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] a_reg;
  logic             borrow;
  logic [CNT_W-1:0] cnt;

  logic             d_bit;
  logic             borrow_next;
  logic [WIDTH-1:0] a_next;

  function automatic logic fs_diff(input logic x, input logic y, input logic bin);
    return x ^ y ^ bin;
  endfunction

  function automatic logic fs_borrow(input logic x, input logic y, input logic bin);
    return (~x & y) | (~x & bin) | (y & bin);
  endfunction

  always_comb begin
    d_bit       = fs_diff(sum_reg[0], b_reg[0], borrow);
    borrow_next = fs_borrow(sum_reg[0], b_reg[0], borrow);
    a_next      = {d_bit, a_reg[WIDTH-1:1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      sum_reg  <= '0;
      cout_reg <= 1'b0;
      b_reg    <= '0;
      a_reg    <= '0;
      borrow   <= 1'b0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      a        <= '0;
      valid    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            sum_reg  <= sum[WIDTH-1:0];
            cout_reg <= sum[WIDTH];
            b_reg    <= b;
            a_reg    <= '0;
            borrow   <= cin;
            cnt      <= '0;
            busy     <= 1'b1;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          a_reg   <= a_next;
          sum_reg <= sum_reg >> 1;
          b_reg   <= b_reg >> 1;
          borrow  <= borrow_next;
          cnt     <= cnt + 1'b1;
          // Final bit: publish result on the same edge that enters DONE.
          if (cnt == LAST_BIT) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            a     <= a_next;
            valid <= ~(cout_reg ^ borrow_next);
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sum_decoder.sv
// Scoreboard bench for serial_sum_decoder: stimulus pushes expected {a,valid},
// a monitor pops and compares on every done pulse.
module tb_serial_sum_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [4:0] sum = '0;
  logic [3:0] b = '0;
  logic       cin = 1'b0;
  logic       busy;
  logic       done;
  logic [3:0] a;
  logic       valid;

  int checks = 0;
  int errors = 0;
  logic [4:0] exp_q[$];

  serial_sum_decoder #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .sum(sum), .b(b), .cin(cin),
    .busy(busy), .done(done), .a(a), .valid(valid)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done) begin
      logic [4:0] exp;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: a=%0d valid=%0b but no result expected", a, valid);
      end else begin
        exp = exp_q.pop_front();
        if ({a, valid} !== exp) begin
          errors++;
          $display("FAIL result: got a=%0d valid=%0b, expected a=%0d valid=%0b",
                   a, valid, exp[4:1], exp[0]);
        end
      end
    end
  end

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  task automatic op(input logic [4:0] s, input logic [3:0] bb, input logic c,
                    input logic [3:0] ea, input logic ev, input bit timing);
    int cycles;
    int bcnt;
    @(negedge clk);
    sum = s; b = bb; cin = c; start = 1'b1;
    exp_q.push_back({ea, ev});
    @(negedge clk);
    start = 1'b0;
    cycles = 1;
    bcnt = 0;
    while (!done && cycles < 20) begin
      if (busy) bcnt++;
      @(negedge clk);
      cycles++;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL done_timeout: got no done within %0d cycles, expected done", cycles);
    end
    if (timing) begin
      check("done_latency", cycles, 5);
      check("busy_cycles", bcnt, 4);
      @(negedge clk);
      check("done_single_pulse", int'(done), 0);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_a", int'(a), 0);
    check("reset_valid", int'(valid), 0);
    rst = 1'b0;

    op(5'd9, 4'd5, 1'b1, 4'd3, 1'b1, 1'b1);
    op(5'd31, 4'd15, 1'b1, 4'd15, 1'b1, 1'b1);
    op(5'd0, 4'd0, 1'b1, 4'd15, 1'b0, 1'b0);
    op(5'd20, 4'd0, 1'b0, 4'd4, 1'b0, 1'b0);

    // Second start while busy must be ignored.
    @(negedge clk);
    sum = 5'd9; b = 4'd5; cin = 1'b1; start = 1'b1;
    exp_q.push_back({4'd3, 1'b1});
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    sum = 5'd20; b = 4'd0; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    check("ignored_start_drained", exp_q.size(), 0);

    // Valid result beforehand so the async clear is observable.
    op(5'd9, 4'd5, 1'b1, 4'd3, 1'b1, 1'b0);
    @(negedge clk);
    sum = 5'd15; b = 4'd1; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_busy", int'(busy), 0);
    check("async_rst_done", int'(done), 0);
    check("async_rst_a", int'(a), 0);
    check("async_rst_valid", int'(valid), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("no_done_after_rst", int'(done), 0);
    op(5'd6, 4'd2, 1'b0, 4'd4, 1'b1, 1'b1);

    for (int ai = 0; ai < 16; ai++)
      for (int bi = 0; bi < 16; bi++)
        for (int ci = 0; ci < 2; ci++)
          op(5'(ai + bi + ci), 4'(bi), 1'(ci), 4'(ai), 1'b1, 1'b0);

    repeat (10) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
